naneye_session_ctrl: RTL and testbench
======================================

# naneye_session_ctrl

Session sequencer for the NanEye receive chain, in the 48 MHz system-clock domain. It brings the chain up from reset, issues the decoder resync, gates the decoder enable, and launches CONFIG_TX exactly once per pending register update, aligned to a frame start. It watches for lost frames, decoder errors and stuck configuration transfers, recovers with bounded retries, and reports a sticky fault when recovery fails.

## Interface
Parameters:
- C_FRAME_TIMEOUT, 4800000: max cycles between FRAME_START pulses (100 ms @ 48 MHz)
- C_CFG_TIMEOUT, 2048: max cycles from CONFIG_EN to CONFIG_DONE
- C_RSYNC_LEN, 16: RSYNC pulse width in cycles (≥1)
- C_MAX_RETRY, 3: consecutive failed recoveries before FAULT (1..3)
- C_CNT_W, 16: FRAME_COUNT width

Ports:
- CLOCK  in  1  system clock, 48 MHz
- RESET  in  1  reset, synchronous, active-high
- ENABLE  in  1  session enable (level)
- FRAME_START  in  1  one-cycle pulse, already synchronised to CLOCK
- CONFIG_DONE  in  1  one-cycle pulse from CONFIG_TX TX_END
- DEC_ERROR  in  1  decoder/deserialiser error pulse, synchronised
- CFG_REQ  in  1  one-cycle pulse: register bank changed, config pending
- DEC_ENABLE  out  1  decoder enable
- RSYNC  out  1  decoder resync request
- CONFIG_EN  out  1  one-cycle start pulse to CONFIG_TX
- STREAM_OK  out  1  high while in STREAM
- FAULT  out  1  sticky fault indicator
- STATE_OUT  out  3  current state encoding
- RETRY_COUNT  out  2  consecutive failure count
- FRAME_COUNT  out  C_CNT_W  frames received in STREAM, wraps

## Operation
States (STATE_OUT): IDLE=0, RESYNC=1, WAIT_FRAME=2, CONFIG=3, STREAM=4, FAULT=5.
- IDLE: all outputs 0. ENABLE=1 → RESYNC.
- RESYNC: RSYNC=1, DEC_ENABLE=0 for exactly C_RSYNC_LEN cycles. Sets `cfg_pending`, so every (re)start reconfigures the sensor. Then → WAIT_FRAME.
- WAIT_FRAME: DEC_ENABLE=1, frame timer running.
  - FRAME_START with cfg_pending → CONFIG.
  - FRAME_START without cfg_pending → STREAM.
  - Timer reaches C_FRAME_TIMEOUT → fail.
- CONFIG: DEC_ENABLE=1. CONFIG_EN=1 on the first cycle of the state only.
  - CONFIG_DONE → STREAM, clears cfg_pending and RETRY_COUNT.
  - C_CFG_TIMEOUT cycles elapsed without CONFIG_DONE → fail.
  - FRAME_START is ignored in this state.
- STREAM: DEC_ENABLE=1, STREAM_OK=1.
  - Each FRAME_START increments FRAME_COUNT and restarts the frame timer.
  - FRAME_START with cfg_pending → CONFIG.
  - DEC_ERROR or frame timeout → fail.
- fail: RETRY_COUNT+1. If the new value equals C_MAX_RETRY → FAULT, otherwise → RESYNC.
- FAULT: FAULT=1, DEC_ENABLE=0. Leaves only via ENABLE=0.
- ENABLE=0 in any state → IDLE next cycle. Clears RETRY_COUNT and cfg_pending; FRAME_COUNT is held.

Rules:
- cfg_pending is set by CFG_REQ in any state and cleared by CONFIG_DONE.
- CFG_REQ and CONFIG_DONE in the same cycle: pending stays set, so a second CONFIG follows on the next frame.
- Priority, highest first: RESET > ENABLE=0 > DEC_ERROR > FRAME_START > timeout.
- FRAME_START and timeout in the same cycle: the frame wins.
- RESET forces IDLE and zeroes every counter, flag and output.

## Timing
- All outputs are registered. Reset value of every output is 0, and STATE_OUT=IDLE.
- ENABLE rise at edge n → STATE_OUT=RESYNC and RSYNC=1 from edge n+1. RSYNC falls after C_RSYNC_LEN cycles.
- FRAME_START sampled at edge n in WAIT_FRAME/STREAM with cfg_pending → CONFIG_EN=1 for edge n+1 only.
- CONFIG_DONE at edge n → STREAM_OK=1 at edge n+1.
- The frame timer counts cycles since state entry or since the last FRAME_START. Timeout fires when count == C_FRAME_TIMEOUT−1. The same scheme applies to the config timer.
- FRAME_COUNT updates one cycle after FRAME_START.
- RETRY_COUNT saturates at C_MAX_RETRY.

## Structure
- Shared package/header naneye_pkg holds the state encodings and the STATE_OUT width, which the debug/I2C register map also uses.
- One sub-module, naneye_wd_timer: a loadable down-counter with a clear input and an expiry pulse. It is instantiated twice, once for the frame timeout and once for the config timeout. It is parameterised by width and terminal count.

## Test plan
All scenarios use C_FRAME_TIMEOUT=100, C_CFG_TIMEOUT=20, C_RSYNC_LEN=4, C_MAX_RETRY=3.
1. Bring-up: ENABLE=1 → RSYNC high for exactly 4 cycles. FRAME_START → CONFIG_EN 1-cycle pulse. CONFIG_DONE 10 cycles later → STREAM_OK=1 and STATE_OUT=4.
2. Streaming and reconfig: in STREAM, send 5 FRAME_START pulses → FRAME_COUNT=5. Then CFG_REQ, then FRAME_START → exactly one CONFIG_EN. CONFIG_DONE → back to STREAM.
3. Config timeout: withhold CONFIG_DONE → at 20 cycles, RETRY_COUNT=1 and RSYNC reasserts. Repeat twice more → FAULT=1, DEC_ENABLE=0, STATE_OUT=5. ENABLE=0 → IDLE with RETRY_COUNT=0.
4. Frame loss: in STREAM, no FRAME_START for 100 cycles → RESYNC. Then in STREAM, FRAME_START on the timeout cycle → stays in STREAM.
5. Collisions: DEC_ERROR together with FRAME_START → RESYNC, FRAME_COUNT unchanged. CFG_REQ together with CONFIG_DONE → STREAM entered and a second CONFIG_EN on the next frame.
6. Reset mid-CONFIG: RESET → all outputs 0 on the next edge, FRAME_COUNT=0, no CONFIG_EN afterwards until the bring-up sequence repeats.

Source files
------------

// File: rtl/naneye_pkg.sv
//------------------------------------------------------------------------------
// naneye_pkg : state encodings and widths shared with the NanEye register map
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package naneye_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_RESYNC     = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_CONFIG     = 3'd3,
    ST_STREAM     = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  // Width needed to hold the value term-1 (at least one bit).
  function automatic int cnt_width(input int term);
    return (term < 2) ? 1 : $clog2(term);
  endfunction

endpackage

`default_nettype wire

// File: rtl/naneye_session_ctrl_if.sv
//------------------------------------------------------------------------------
// naneye_session_ctrl_if : control/status bundle between system and sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface naneye_session_ctrl_if #(
  parameter int C_CNT_W = 16
);
  import naneye_pkg::*;

  logic                 ENABLE;
  logic                 FRAME_START;
  logic                 CONFIG_DONE;
  logic                 DEC_ERROR;
  logic                 CFG_REQ;
  logic                 DEC_ENABLE;
  logic                 RSYNC;
  logic                 CONFIG_EN;
  logic                 STREAM_OK;
  logic                 FAULT;
  logic [STATE_W-1:0]   STATE_OUT;
  logic [RETRY_W-1:0]   RETRY_COUNT;
  logic [C_CNT_W-1:0]   FRAME_COUNT;

  modport master (
    output ENABLE, FRAME_START, CONFIG_DONE, DEC_ERROR, CFG_REQ,
    input  DEC_ENABLE, RSYNC, CONFIG_EN, STREAM_OK, FAULT,
           STATE_OUT, RETRY_COUNT, FRAME_COUNT
  );

  modport slave (
    input  ENABLE, FRAME_START, CONFIG_DONE, DEC_ERROR, CFG_REQ,
    output DEC_ENABLE, RSYNC, CONFIG_EN, STREAM_OK, FAULT,
           STATE_OUT, RETRY_COUNT, FRAME_COUNT
  );

endinterface

`default_nettype wire

// File: rtl/naneye_wd_timer.sv
//------------------------------------------------------------------------------
// naneye_wd_timer : loadable watchdog down-counter with clear and expiry flag
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module naneye_wd_timer #(
  parameter int W    = 8,
  parameter int TERM = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [W-1:0] LOAD_VAL = W'(TERM - 1);

  logic [W-1:0] cnt_q;

  // Reload value TERM-1 means expiry is seen on the TERM-th running cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i || load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/naneye_session_ctrl.sv
//------------------------------------------------------------------------------
// naneye_session_ctrl : NanEye receive-chain bring-up, config and recovery FSM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module naneye_session_ctrl
  import naneye_pkg::*;
#(
  parameter int C_FRAME_TIMEOUT = 4800000,
  parameter int C_CFG_TIMEOUT   = 2048,
  parameter int C_RSYNC_LEN     = 16,
  parameter int C_MAX_RETRY     = 3,
  parameter int C_CNT_W         = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  naneye_session_ctrl_if.slave  bus
);

  localparam int FRM_W = cnt_width(C_FRAME_TIMEOUT);
  localparam int CFG_W = cnt_width(C_CFG_TIMEOUT);
  localparam int RS_W  = cnt_width(C_RSYNC_LEN);
  localparam logic [RS_W-1:0]    RS_LAST   = RS_W'(C_RSYNC_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(C_MAX_RETRY);

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
  logic [C_CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [RS_W-1:0]      rs_cnt_q, rs_cnt_d;
  logic                 dec_en_q, rsync_q, cfg_en_q, stream_ok_q, fault_q;
  logic                 fail;
  logic                 frm_active, cfg_active, frm_exp, cfg_exp;

  assign frm_active = (state_q == ST_WAIT_FRAME) || (state_q == ST_STREAM);
  assign cfg_active = (state_q == ST_CONFIG);

  naneye_wd_timer #(.W(FRM_W), .TERM(C_FRAME_TIMEOUT)) u_frame_wd (
    .clk      (CLOCK),
    .rst      (RESET),
    .clr_i    (!frm_active),
    .load_i   (bus.FRAME_START && frm_active),
    .en_i     (frm_active),
    .expire_o (frm_exp)
  );

  naneye_wd_timer #(.W(CFG_W), .TERM(C_CFG_TIMEOUT)) u_cfg_wd (
    .clk      (CLOCK),
    .rst      (RESET),
    .clr_i    (!cfg_active),
    .load_i   (1'b0),
    .en_i     (cfg_active),
    .expire_o (cfg_exp)
  );

  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q || bus.CFG_REQ;
    retry_d  = retry_q;
    fcnt_d   = fcnt_q;
    rs_cnt_d = '0;
    fail     = 1'b0;
    if (!bus.ENABLE) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_RESYNC;
        ST_RESYNC: begin
          pend_d = 1'b1;
          if (rs_cnt_q == RS_LAST) state_d = ST_WAIT_FRAME;
          else                     rs_cnt_d = rs_cnt_q + RS_W'(1);
        end
        ST_WAIT_FRAME: begin
          if (bus.FRAME_START) state_d = pend_q ? ST_CONFIG : ST_STREAM;
          else if (frm_exp)    fail = 1'b1;
        end
        ST_CONFIG: begin
          // A request landing with DONE keeps pending so the next frame reconfigures.
          if (bus.CONFIG_DONE) begin
            state_d = ST_STREAM;
            retry_d = '0;
            if (!bus.CFG_REQ) pend_d = 1'b0;
          end else if (cfg_exp) begin
            fail = 1'b1;
          end
        end
        ST_STREAM: begin
          if (bus.DEC_ERROR) begin
            fail = 1'b1;
          end else if (bus.FRAME_START) begin
            fcnt_d = fcnt_q + C_CNT_W'(1);
            if (pend_q) state_d = ST_CONFIG;
          end else if (frm_exp) begin
            fail = 1'b1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
      if (fail) begin
        retry_d = retry_inc;
        state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESYNC;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      retry_q     <= '0;
      fcnt_q      <= '0;
      rs_cnt_q    <= '0;
      dec_en_q    <= 1'b0;
      rsync_q     <= 1'b0;
      cfg_en_q    <= 1'b0;
      stream_ok_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      retry_q     <= retry_d;
      fcnt_q      <= fcnt_d;
      rs_cnt_q    <= rs_cnt_d;
      dec_en_q    <= state_d inside {ST_WAIT_FRAME, ST_CONFIG, ST_STREAM};
      rsync_q     <= (state_d == ST_RESYNC);
      cfg_en_q    <= (state_d == ST_CONFIG) && (state_q != ST_CONFIG);
      stream_ok_q <= (state_d == ST_STREAM);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign bus.DEC_ENABLE  = dec_en_q;
  assign bus.RSYNC       = rsync_q;
  assign bus.CONFIG_EN   = cfg_en_q;
  assign bus.STREAM_OK   = stream_ok_q;
  assign bus.FAULT       = fault_q;
  assign bus.STATE_OUT   = state_q;
  assign bus.RETRY_COUNT = retry_q;
  assign bus.FRAME_COUNT = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_naneye_session_ctrl.sv
//------------------------------------------------------------------------------
// tb_naneye_session_ctrl : scenario tasks plus randomized run against a model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_naneye_session_ctrl;

  localparam int FT = 100;
  localparam int CT = 20;
  localparam int RS = 4;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  naneye_session_ctrl_if #(.C_CNT_W(16)) bus ();

  naneye_session_ctrl #(
    .C_FRAME_TIMEOUT (FT),
    .C_CFG_TIMEOUT   (CT),
    .C_RSYNC_LEN     (RS),
    .C_MAX_RETRY     (MR),
    .C_CNT_W         (16)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase name, cycles spent in the phase, pending flag, counters.
  int          m_st = 0;
  int          m_t = 0;
  bit          m_pend = 0;
  bit          m_cfgen = 0;
  logic [1:0]  m_retry = '0;
  logic [15:0] m_fc = '0;

  task automatic model_step();
    int nst;
    bit fail_now;
    bit pend_old;
    if (rst) begin
      m_st = 0; m_t = 0; m_pend = 0; m_retry = 0; m_fc = 0; m_cfgen = 0;
      return;
    end
    if (!bus.ENABLE) begin
      m_st = 0; m_t = 0; m_pend = 0; m_retry = 0; m_cfgen = 0;
      return;
    end
    pend_old = m_pend;
    m_pend   = m_pend | bus.CFG_REQ;
    nst      = m_st;
    fail_now = 0;
    case (m_st)
      0: nst = 1;
      1: begin
        m_pend = 1;
        if (m_t == RS - 1) nst = 2; else m_t++;
      end
      2: begin
        if (bus.FRAME_START) nst = pend_old ? 3 : 4;
        else if (m_t == FT - 1) fail_now = 1;
        else m_t++;
      end
      3: begin
        if (bus.CONFIG_DONE) begin
          nst = 4; m_retry = 0;
          if (!bus.CFG_REQ) m_pend = 0;
        end else if (m_t == CT - 1) fail_now = 1;
        else m_t++;
      end
      4: begin
        if (bus.DEC_ERROR) fail_now = 1;
        else if (bus.FRAME_START) begin
          m_fc++; m_t = 0;
          if (pend_old) nst = 3;
        end else if (m_t == FT - 1) fail_now = 1;
        else m_t++;
      end
      default: nst = m_st;
    endcase
    if (fail_now) begin
      if (m_retry < MR) m_retry++;
      nst = (m_retry == MR) ? 5 : 1;
    end
    m_cfgen = (nst == 3) && (m_st != 3);
    if (nst != m_st) m_t = 0;
    m_st = nst;
  endtask

  function automatic logic [25:0] exp_vec();
    return {(m_st >= 2 && m_st <= 4), (m_st == 1), m_cfgen, (m_st == 4), (m_st == 5),
            3'(m_st), m_retry, m_fc};
  endfunction

  function automatic logic [25:0] act_vec();
    return {bus.DEC_ENABLE, bus.RSYNC, bus.CONFIG_EN, bus.STREAM_OK, bus.FAULT,
            bus.STATE_OUT, bus.RETRY_COUNT, bus.FRAME_COUNT};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    bus.FRAME_START = 0;
    bus.CONFIG_DONE = 0;
    bus.DEC_ERROR   = 0;
    bus.CFG_REQ     = 0;
  endtask

  task automatic wait_state(input int s, input int bound, output bit ok);
    int n;
    n = 0;
    while (bus.STATE_OUT !== 3'(s) && n < bound) begin
      tick();
      n++;
    end
    ok = (bus.STATE_OUT === 3'(s));
  endtask

  task automatic test_reset();
    rst = 1; bus.ENABLE = 0;
    tick(); tick();
    checks++;
    if (act_vec() !== 26'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", act_vec(), 26'd0);
    end
    rst = 0;
    tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_bringup();
    int hi;
    bus.ENABLE = 1;
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd1 || bus.RSYNC !== 1'b1) begin
      failures++; $display("FAIL bringup_resync_entry: got state %0d rsync %0b expected 1/1", bus.STATE_OUT, bus.RSYNC);
    end
    hi = 1;
    while (bus.RSYNC === 1'b1 && hi < 20) begin
      tick();
      if (bus.RSYNC === 1'b1) hi++;
    end
    checks++;
    if (hi != RS) begin
      failures++; $display("FAIL bringup_rsync_len: got %0d expected %0d", hi, RS);
    end
    repeat (3) tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL bringup_wait: got %h expected %h", act_vec(), exp_vec());
    end
    bus.FRAME_START = 1;
    tick();
    checks++;
    if (bus.CONFIG_EN !== 1'b1 || bus.STATE_OUT !== 3'd3) begin
      failures++; $display("FAIL bringup_cfg_en: got en %0b state %0d expected 1/3", bus.CONFIG_EN, bus.STATE_OUT);
    end
    tick();
    checks++;
    if (bus.CONFIG_EN !== 1'b0) begin
      failures++; $display("FAIL bringup_cfg_en_width: got %0b expected 0", bus.CONFIG_EN);
    end
    repeat (8) tick();
    bus.CONFIG_DONE = 1;
    tick();
    checks++;
    if (bus.STREAM_OK !== 1'b1 || bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL bringup_stream: got ok %0b state %0d expected 1/4", bus.STREAM_OK, bus.STATE_OUT);
    end
  endtask

  task automatic test_stream_reconfig();
    int pulses;
    for (int i = 0; i < 5; i++) begin
      bus.FRAME_START = 1;
      tick();
      repeat (6) tick();
    end
    checks++;
    if (bus.FRAME_COUNT !== 16'd5 || bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL stream_count: got count %0d state %0d expected 5/4", bus.FRAME_COUNT, bus.STATE_OUT);
    end
    bus.CFG_REQ = 1;
    tick();
    repeat (3) tick();
    checks++;
    if (bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL reconfig_hold: got state %0d expected 4", bus.STATE_OUT);
    end
    bus.FRAME_START = 1;
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (bus.CONFIG_EN === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL reconfig_single_pulse: got %0d expected 1", pulses);
    end
    bus.CONFIG_DONE = 1;
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd4 || bus.FRAME_COUNT !== 16'd6) begin
      failures++; $display("FAIL reconfig_back: got state %0d count %0d expected 4/6", bus.STATE_OUT, bus.FRAME_COUNT);
    end
  endtask

  task automatic test_cfg_timeout();
    int n;
    bit ok;
    for (int r = 1; r <= MR; r++) begin
      if (r == 1) begin
        bus.CFG_REQ = 1;
        tick();
      end else begin
        wait_state(2, 30, ok);
        checks++;
        if (!ok) begin
          failures++; $display("FAIL cfg_to_wait_frame r%0d: got state %0d expected 2", r, bus.STATE_OUT);
        end
      end
      bus.FRAME_START = 1;
      tick();
      n = 1;
      while (bus.STATE_OUT === 3'd3 && n < 40) begin
        tick();
        if (bus.STATE_OUT === 3'd3) n++;
      end
      checks++;
      if (n != CT) begin
        failures++; $display("FAIL cfg_timeout_len r%0d: got %0d expected %0d", r, n, CT);
      end
      checks++;
      if (bus.RETRY_COUNT !== 2'(r)) begin
        failures++; $display("FAIL cfg_retry r%0d: got %0d expected %0d", r, bus.RETRY_COUNT, r);
      end
      checks++;
      if (r < MR && (bus.RSYNC !== 1'b1 || bus.STATE_OUT !== 3'd1)) begin
        failures++; $display("FAIL cfg_resync r%0d: got rsync %0b state %0d expected 1/1", r, bus.RSYNC, bus.STATE_OUT);
      end else if (r == MR && (bus.FAULT !== 1'b1 || bus.DEC_ENABLE !== 1'b0 || bus.STATE_OUT !== 3'd5)) begin
        failures++; $display("FAIL cfg_fault: got fault %0b dec %0b state %0d expected 1/0/5", bus.FAULT, bus.DEC_ENABLE, bus.STATE_OUT);
      end
    end
    repeat (5) tick();
    checks++;
    if (bus.STATE_OUT !== 3'd5) begin
      failures++; $display("FAIL fault_sticky: got state %0d expected 5", bus.STATE_OUT);
    end
    bus.ENABLE = 0;
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd0 || bus.RETRY_COUNT !== 2'd0 || bus.FAULT !== 1'b0) begin
      failures++; $display("FAIL fault_exit: got state %0d retry %0d fault %0b expected 0/0/0", bus.STATE_OUT, bus.RETRY_COUNT, bus.FAULT);
    end
  endtask

  task automatic test_frame_loss();
    int n;
    bit ok;
    bus.ENABLE = 1;
    wait_state(2, 20, ok);
    bus.FRAME_START = 1; tick();
    repeat (3) tick();
    bus.CONFIG_DONE = 1; tick();
    checks++;
    if (!ok || bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL loss_setup: got state %0d expected 4", bus.STATE_OUT);
    end
    n = 1;
    while (bus.STATE_OUT === 3'd4 && n < 200) begin
      tick();
      if (bus.STATE_OUT === 3'd4) n++;
    end
    checks++;
    if (n != FT || bus.STATE_OUT !== 3'd1 || bus.RETRY_COUNT !== 2'd1) begin
      failures++; $display("FAIL loss_timeout: got %0d cycles state %0d retry %0d expected %0d/1/1", n, bus.STATE_OUT, bus.RETRY_COUNT, FT);
    end
    wait_state(2, 20, ok);
    bus.FRAME_START = 1; tick();
    bus.CONFIG_DONE = 1; tick();
    repeat (FT - 1) tick();
    bus.FRAME_START = 1;
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd4 || act_vec() !== exp_vec()) begin
      failures++; $display("FAIL loss_frame_wins: got %h expected %h", act_vec(), exp_vec());
    end
    repeat (50) tick();
    checks++;
    if (bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL loss_timer_restart: got state %0d expected 4", bus.STATE_OUT);
    end
  endtask

  task automatic test_collisions();
    logic [15:0] fc_before;
    bit ok;
    fc_before = m_fc;
    bus.DEC_ERROR = 1; bus.FRAME_START = 1;
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd1 || bus.FRAME_COUNT !== fc_before) begin
      failures++; $display("FAIL err_vs_frame: got state %0d count %0d expected 1/%0d", bus.STATE_OUT, bus.FRAME_COUNT, fc_before);
    end
    wait_state(2, 20, ok);
    bus.FRAME_START = 1; tick();
    tick(); tick();
    bus.CFG_REQ = 1; bus.CONFIG_DONE = 1;
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL req_with_done: got state %0d expected 4", bus.STATE_OUT);
    end
    repeat (3) tick();
    bus.FRAME_START = 1;
    tick();
    checks++;
    if (bus.CONFIG_EN !== 1'b1 || bus.STATE_OUT !== 3'd3) begin
      failures++; $display("FAIL second_config: got en %0b state %0d expected 1/3", bus.CONFIG_EN, bus.STATE_OUT);
    end
    tick();
    bus.CONFIG_DONE = 1;
    tick();
    checks++;
    if (act_vec() !== exp_vec() || bus.STATE_OUT !== 3'd4) begin
      failures++; $display("FAIL second_config_done: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_config();
    int pulses;
    bus.CFG_REQ = 1; tick();
    bus.FRAME_START = 1; tick();
    tick();
    checks++;
    if (bus.STATE_OUT !== 3'd3) begin
      failures++; $display("FAIL mid_config_setup: got state %0d expected 3", bus.STATE_OUT);
    end
    rst = 1;
    tick();
    checks++;
    if (act_vec() !== 26'd0) begin
      failures++; $display("FAIL reset_mid_config: got %h expected %h", act_vec(), 26'd0);
    end
    rst = 0;
    bus.ENABLE = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus.FRAME_START = i[0];
      bus.CONFIG_DONE = ~i[0];
      tick();
      if (bus.CONFIG_EN === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.STATE_OUT !== 3'd0 || bus.FRAME_COUNT !== 16'd0) begin
      failures++; $display("FAIL post_reset_quiet: got pulses %0d state %0d count %0d expected 0/0/0", pulses, bus.STATE_OUT, bus.FRAME_COUNT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 999) == 0);
      bus.ENABLE      = ($urandom_range(0, 399) != 0);
      bus.FRAME_START = ($urandom_range(0, 29) == 0);
      bus.DEC_ERROR   = ($urandom_range(0, 199) == 0);
      bus.CFG_REQ     = ($urandom_range(0, 49) == 0);
      bus.CONFIG_DONE = ($urandom_range(0, 9) == 0);
      tick();
      rst = 0;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1;
    bus.ENABLE = 0; bus.FRAME_START = 0; bus.CONFIG_DONE = 0;
    bus.DEC_ERROR = 0; bus.CFG_REQ = 0;
    test_reset();
    test_bringup();
    test_stream_reconfig();
    test_cfg_timeout();
    test_frame_loss();
    test_collisions();
    test_reset_mid_config();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
